// File: rtl/demux1_2_buffered_pkg.sv
// Shared constants for the write-back 1:2 demux and the operand-side 2:1 mux.
// Op encodings and default sizes live here so both sides agree.
package demux1_2_buffered_pkg;

  localparam logic OP_A = 1'b0;
  localparam logic OP_B = 1'b1;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DEPTH_DEFAULT = 2;

  // True when depth is a power of two and at least 2.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout is the head word, forced to 0 when empty.
// push is ignored while full and pop is ignored while empty.
module demux_fifo
  import demux1_2_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Equal pointers mean empty; equal index with opposite wrap bits means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the empty mask hides stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/demux1_2_buffered.sv
// 1:2 buffered demux: steers each accepted word into FIFO A (Op=0) or FIFO B (Op=1).
// Handshake: a word moves on any edge where valid && ready; InReady uses only registered full flags.
module demux1_2_buffered
  import demux1_2_buffered_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Op,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic             AValid,
  input  logic             AReady,
  output logic [WIDTH-1:0] OutB,
  output logic             BValid,
  input  logic             BReady,
  output logic             Busy
);

  logic a_empty;
  logic a_full;
  logic b_empty;
  logic b_full;
  logic target_full;
  logic accept;
  logic push_a;
  logic push_b;

  // A full target refuses even when it is popped this cycle, keeping Ready free of AReady/BReady.
  assign target_full = (Op == OP_B) ? b_full : a_full;
  assign InReady     = !Reset && !target_full;
  assign accept      = InValid && InReady;
  assign push_a      = accept && (Op == OP_A);
  assign push_b      = accept && (Op == OP_B);

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_a (
    .clk  (CLK),
    .reset(Reset),
    .push (push_a),
    .pop  (AReady),
    .din  (In),
    .dout (OutA),
    .empty(a_empty),
    .full (a_full)
  );

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_b (
    .clk  (CLK),
    .reset(Reset),
    .push (push_b),
    .pop  (BReady),
    .din  (In),
    .dout (OutB),
    .empty(b_empty),
    .full (b_full)
  );

  assign AValid = !a_empty;
  assign BValid = !b_empty;
  assign Busy   = AValid || BValid;

endmodule

// File: tb/tb_demux1_2_buffered.sv
// Directed bench for demux1_2_buffered: per-cycle vector table plus a wrap-around stream to B.
module tb_demux1_2_buffered;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_a;
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] out_b;
  logic         b_valid;
  logic         b_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  demux1_2_buffered #(.WIDTH(W), .DEPTH(2)) dut (
    .CLK(clk), .Reset(rst), .In(din), .Op(op), .InValid(in_valid), .InReady(in_ready),
    .OutA(out_a), .AValid(a_valid), .AReady(a_ready),
    .OutB(out_b), .BValid(b_valid), .BReady(b_ready), .Busy(busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst, vld, op;
    logic [W-1:0] d;
    logic         ar, br;
    logic         ir, av;
    logic [W-1:0] oa;
    logic         bv;
    logic [W-1:0] ob;
    logic         bz;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic v, logic o, logic [W-1:0] d, logic ar, logic br,
                              logic ir, logic av, logic [W-1:0] oa, logic bv,
                              logic [W-1:0] ob, logic bz);
    vec_t t;
    t.rst = r; t.vld = v; t.op = o; t.d = d; t.ar = ar; t.br = br;
    t.ir = ir; t.av = av; t.oa = oa; t.bv = bv; t.ob = ob; t.bz = bz;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Driver: present one row, check before the edge, then let the edge happen.
  task automatic apply_row(input int i);
    rst = vecs[i].rst; in_valid = vecs[i].vld; op = vecs[i].op; din = vecs[i].d;
    a_ready = vecs[i].ar; b_ready = vecs[i].br;
    @(negedge clk);
    check("in_ready", i, W'(in_ready), W'(vecs[i].ir));
    check("a_valid",  i, W'(a_valid),  W'(vecs[i].av));
    check("out_a",    i, out_a,        vecs[i].oa);
    check("b_valid",  i, W'(b_valid),  W'(vecs[i].bv));
    check("out_b",    i, out_b,        vecs[i].ob);
    check("busy",     i, W'(busy),     W'(vecs[i].bz));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int recv;
    int cyc;

    //               rst vld op d        ar br | ir av oa       bv ob       busy
    vecs[0]  = mk(1, 1, 0, 16'hFFFF, 0, 0,  0, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[2]  = mk(0, 1, 0, 16'h1234, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[3]  = mk(0, 1, 1, 16'hABCD, 1, 1,  1, 1, 16'h1234, 0, 16'h0000, 1);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 1, 16'hABCD, 1);
    vecs[5]  = mk(0, 0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[6]  = mk(0, 1, 0, 16'h0001, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[7]  = mk(0, 1, 0, 16'h0002, 0, 0,  1, 1, 16'h0001, 0, 16'h0000, 1);
    vecs[8]  = mk(0, 1, 0, 16'h0003, 0, 0,  0, 1, 16'h0001, 0, 16'h0000, 1);
    vecs[9]  = mk(0, 1, 0, 16'h0003, 0, 0,  0, 1, 16'h0001, 0, 16'h0000, 1);
    vecs[10] = mk(0, 1, 1, 16'h00B0, 0, 0,  1, 1, 16'h0001, 0, 16'h0000, 1);
    vecs[11] = mk(0, 0, 1, 16'h0000, 0, 0,  1, 1, 16'h0001, 1, 16'h00B0, 1);
    vecs[12] = mk(0, 1, 0, 16'h0003, 1, 0,  0, 1, 16'h0001, 1, 16'h00B0, 1);
    vecs[13] = mk(0, 1, 0, 16'h0003, 0, 0,  1, 1, 16'h0002, 1, 16'h00B0, 1);
    vecs[14] = mk(0, 0, 1, 16'h0000, 1, 1,  1, 1, 16'h0002, 1, 16'h00B0, 1);
    vecs[15] = mk(0, 0, 1, 16'h0000, 1, 0,  1, 1, 16'h0003, 0, 16'h0000, 1);
    vecs[16] = mk(0, 0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[17] = mk(0, 1, 0, 16'hA001, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[18] = mk(0, 1, 0, 16'hA002, 0, 0,  1, 1, 16'hA001, 0, 16'h0000, 1);
    vecs[19] = mk(0, 1, 1, 16'hB001, 0, 0,  1, 1, 16'hA001, 0, 16'h0000, 1);
    vecs[20] = mk(1, 1, 0, 16'hDEAD, 0, 0,  0, 1, 16'hA001, 1, 16'hB001, 1);
    vecs[21] = mk(0, 1, 0, 16'h5555, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[22] = mk(0, 0, 0, 16'h0000, 1, 0,  1, 1, 16'h5555, 0, 16'h0000, 1);
    vecs[23] = mk(0, 0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0);

    rst = 1'b1; in_valid = 1'b1; op = 1'b0; din = 16'hFFFF; a_ready = 1'b0; b_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, steering, full/stall, full-while-popping
    for (int i = 0; i <= 16; i++) apply_row(i);

    // Wrap-around: 10 words to B while BReady toggles 1,0,1,0...
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      rst = 1'b0; op = 1'b1; a_ready = 1'b0;
      in_valid = (sent < 10);
      din = W'(sent);
      b_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (b_valid && b_ready) begin
        if (exp_q.size() == 0) begin
          check("wrap_extra", cyc, out_b, 16'hFFFF ^ out_b);
        end else begin
          check("wrap_data", cyc, out_b, exp_q.pop_front());
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(din);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("wrap_recv", cyc, W'(recv), W'(10));
    check("wrap_sent", cyc, W'(sent), W'(10));
    check("wrap_left", cyc, W'(exp_q.size()), W'(0));
    in_valid = 1'b0; b_ready = 1'b0;
    @(negedge clk);
    check("wrap_busy",   cyc, W'(busy),    W'(0));
    check("wrap_bvalid", cyc, W'(b_valid), W'(0));
    @(posedge clk);
    #1;

    // Reset mid-stream and a fresh word afterwards
    for (int i = 17; i < NV; i++) apply_row(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
